key_event_queue: RTL and testbench

Collects the one-cycle release pulses from up to N_KEYS debounce filters and stamps each with a millisecond timestamp. The stamped events are buffered in a FIFO and handed to the embedded CPU / bus-slave side through a valid/ready read port. It is the consumer end of the key-filter chain: filters produce events, this block queues them until software reads them. It also flags lost events through a sticky overflow bit.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_evt_fifo.sv | 61 ++++++
 rtl/key_event_queue.sv | 145 ++++++++++++++
 tb/tb_key_event_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared width helpers for the key event queue.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
//
// The event record itself is declared as a packed struct inside each user,
// sized by that site's localparams (KEY_IDX_W from key_idx_w(), TS_W), since
// a package cannot carry per-instance widths.
package key_pkg;

  // Width of a key index; a single key still gets a 1-bit index field.
  function automatic int key_idx_w(input int n_keys);
    return (n_keys > 2) ? $clog2(n_keys) : 1;
  endfunction

  // Total packed width of one {key index, timestamp} event.
  function automatic int evt_w(input int n_keys, input int ts_w);
    return key_idx_w(n_keys) + ts_w;
  endfunction

  // Prescaler width for a divide-by-div counter (at least 1 bit).
  function automatic int pre_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous show-ahead FIFO holding stamped key events.
// Latency: a push is visible at o_head on the cycle after the write edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge;
//               pop is ignored when empty.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset (pointers only)
//   i_push, i_push_dat  write request and data
//   i_pop               consume head entry
//   o_head              head entry (valid while !o_empty)
//   o_full, o_empty     occupancy flags
//   o_level             number of stored entries, 0..DEPTH
module key_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference
  // means full.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_level = wr_ptr - rd_ptr;
  assign o_head  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: timestamps one-cycle key release pulses and queues them for the CPU.
// Latency: 2 cycles from pulse-high cycle to o_evt_valid (pending stage + FIFO write).
// Backpressure: full FIFO parks one event per key in its pending slot; a second
//               pulse on a parked key is dropped and sets sticky o_overflow.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_key_pulse      one-cycle event pulse per key
//   o_evt_valid      head event available; i_evt_ready pops it
//   o_evt_key/ts     key index and ms timestamp of the head event (0 when empty)
//   o_level          FIFO occupancy
//   o_overflow       sticky drop flag, cleared by i_ovf_clr (a same-cycle drop wins)
module key_event_queue
  import key_pkg::*;
#(
  parameter int I_CLK_FREQ = 50_000_000,
  parameter int N_KEYS     = 4,
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16,
  localparam int KEY_IDX_W = key_idx_w(N_KEYS),
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_KEYS-1:0]    i_key_pulse,
  output logic                 o_evt_valid,
  input  logic                 i_evt_ready,
  output logic [KEY_IDX_W-1:0] o_evt_key,
  output logic [TS_W-1:0]      o_evt_ts,
  output logic [LVL_W-1:0]     o_level,
  output logic                 o_overflow,
  input  logic                 i_ovf_clr
);

  localparam int DIV   = I_CLK_FREQ / 1000;
  localparam int PRE_W = pre_w(DIV);
  localparam int EVT_W = evt_w(N_KEYS, TS_W);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic [TS_W-1:0]      ts;
  } evt_t;

  // ms timebase
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [TS_W-1:0]  ts_ms;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre   <= '0;
      ts_ms <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) ts_ms <= ts_ms + TS_W'(1);
    end
  end

  // Pending slots and priority pick
  logic [N_KEYS-1:0]    pending;
  logic [TS_W-1:0]      pend_ts [N_KEYS];
  logic                 cand_vld;
  logic [KEY_IDX_W-1:0] cand_idx;
  logic [TS_W-1:0]      cand_ts;
  logic [N_KEYS-1:0]    cand_sel;

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    cand_ts  = '0;
    cand_sel = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (pending[k] && !cand_vld) begin
        cand_vld    = 1'b1;
        cand_idx    = KEY_IDX_W'(k);
        cand_ts     = pend_ts[k];
        cand_sel[k] = 1'b1;
      end
    end
  end

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              wr;
  logic [N_KEYS-1:0] clr;
  logic [N_KEYS-1:0] drop;
  evt_t              wr_evt;
  evt_t              head_evt;

  assign pop    = o_evt_valid && i_evt_ready;
  assign wr     = cand_vld && (!fifo_full || pop);
  assign clr    = cand_sel & {N_KEYS{wr}};
  // A pulse on a slot that is leaving this edge is a reload, not a loss.
  assign drop   = i_key_pulse & pending & ~clr;
  assign wr_evt = '{key: cand_idx, ts: cand_ts};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      for (int k = 0; k < N_KEYS; k++) pend_ts[k] <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        // Capture (including set-wins over a same-edge drain) beats clear;
        // a dropped pulse leaves the parked timestamp untouched.
        if (i_key_pulse[k] && !drop[k]) begin
          pending[k] <= 1'b1;
          pend_ts[k] <= ts_ms;
        end else if (clr[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        o_overflow <= 1'b0;
    else if (|drop)      o_overflow <= 1'b1;
    else if (i_ovf_clr)  o_overflow <= 1'b0;
  end

  key_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (wr),
    .i_push_dat (wr_evt),
    .i_pop      (pop),
    .o_head     (head_evt),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_level    (o_level)
  );

  // Head fields are forced to zero while empty so the port never shows stale data.
  assign o_evt_valid = !fifo_empty;
  assign o_evt_key   = o_evt_valid ? head_evt.key : '0;
  assign o_evt_ts    = o_evt_valid ? head_evt.ts  : '0;

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pulse = '0;
  logic       ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [3:0] evt_ts;
  logic [3:0] level;
  logic       overflow;

  always #5 clk = ~clk;

  key_event_queue #(
    .I_CLK_FREQ (10_000),
    .N_KEYS     (4),
    .DEPTH      (8),
    .TS_W       (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_pulse (pulse),
    .o_evt_valid (evt_valid),
    .i_evt_ready (ready),
    .o_evt_key   (evt_key),
    .o_evt_ts    (evt_ts),
    .o_level     (level),
    .o_overflow  (overflow),
    .i_ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic [1:0] key;
    logic [3:0] ts;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges;

  // Clock edges since reset release; 10 edges make one ms at 10 kHz.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic logic [3:0] cur_ts();
    return 4'((edges / 10) % 16);
  endfunction

  task automatic push_exp(input int k);
    exp_t e;
    e.key = 2'(k);
    e.ts  = cur_ts();
    sb.push_back(e);
  endtask

  task automatic wait_ts(input logic [3:0] t);
    int guard = 0;
    while (cur_ts() != t && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ts: timestamp %0d never reached", t);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_cmp++; if (level !== 4'd0)     begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (evt_key !== 2'd0)   begin n_bad++; $display("FAIL reset_key: got %0d want 0", evt_key); end
    n_cmp++; if (evt_ts !== 4'd0)    begin n_bad++; $display("FAIL reset_ts: got %0d want 0", evt_ts); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    wait_ts(4'd5);
    pulse[2] = 1'b1; push_exp(2);
    @(negedge clk); pulse = '0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: valid %b want 0", evt_valid); end
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", evt_valid); end
    n_cmp++; if (evt_key !== e.key)  begin n_bad++; $display("FAIL single_key: got %0d want %0d", evt_key, e.key); end
    n_cmp++; if (evt_ts !== 4'd5)    begin n_bad++; $display("FAIL single_ts: got %0d want 5", evt_ts); end
    n_cmp++; if (level !== 4'd1)     begin n_bad++; $display("FAIL single_level: got %0d want 1", level); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid: got %b want 0", evt_valid); end
    n_cmp++; if (level !== 4'd0)     begin n_bad++; $display("FAIL single_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    wait_ts(4'd7);
    pulse = 4'b1011; push_exp(0); push_exp(1); push_exp(3);
    @(negedge clk); pulse = '0;
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL simul_level0: got %0d want 0", level); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++; if (level !== 4'(i)) begin n_bad++; $display("FAIL simul_level%0d: got %0d want %0d", i, level, i); end
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      n_cmp++; if (evt_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid%0d: got %b want 1", i, evt_valid); end
      n_cmp++; if (evt_key !== e.key)  begin n_bad++; $display("FAIL simul_key%0d: got %0d want %0d", i, evt_key, e.key); end
      n_cmp++; if (evt_ts !== 4'd7)    begin n_bad++; $display("FAIL simul_ts%0d: got %0d want 7", i, evt_ts); end
      @(negedge clk);
    end
    ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL simul_empty: valid %b want 0", evt_valid); end
  endtask

  task automatic test_full_pending();
    exp_t e;
    ready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      pulse[0] = 1'b1; push_exp(0);
      @(negedge clk); pulse = '0;
      @(negedge clk); @(negedge clk);
    end
    n_cmp++; if (level !== 4'd8)         begin n_bad++; $display("FAIL full_level: got %0d want 8", level); end
    n_cmp++; if (overflow !== 1'b0)      begin n_bad++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
    n_cmp++; if (dut.pending[0] !== 1'b1) begin n_bad++; $display("FAIL full_pending: got %b want 1", dut.pending[0]); end
    pulse[0] = 1'b1;
    @(negedge clk); pulse = '0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_drop_ovf: got %b want 1", overflow); end
    e = sb.pop_front();
    n_cmp++; if (evt_ts !== e.ts) begin n_bad++; $display("FAIL full_pop_ts: got %0d want %0d", evt_ts, e.ts); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    n_cmp++; if (level !== 4'd8)          begin n_bad++; $display("FAIL full_refill_level: got %0d want 8", level); end
    n_cmp++; if (dut.pending[0] !== 1'b0) begin n_bad++; $display("FAIL full_refill_pending: got %b want 0", dut.pending[0]); end
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_first: got %b want 0", overflow); end
    pulse[0] = 1'b1; push_exp(0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk); pulse = '0; ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_alone: got %b want 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    exp_t e;
    int   guard = 0;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      n_cmp++; if (evt_key !== e.key || evt_ts !== e.ts) begin n_bad++; $display("FAIL pp_head%0d: got %0d/%0d want %0d/%0d", i, evt_key, evt_ts, e.key, e.ts); end
      pulse[0] = 1'b1; push_exp(0);
      @(negedge clk);
      n_cmp++; if (level !== 4'd8)    begin n_bad++; $display("FAIL pp_level%0d: got %0d want 8", i, level); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL pp_ovf%0d: got %b want 0", i, overflow); end
    end
    pulse = '0;
    while (sb.size() > 0 && guard < 40) begin
      e = sb.pop_front();
      n_cmp++; if (evt_valid !== 1'b1 || evt_key !== e.key || evt_ts !== e.ts) begin n_bad++; $display("FAIL pp_drain%0d: got %b %0d/%0d want 1 %0d/%0d", guard, evt_valid, evt_key, evt_ts, e.key, e.ts); end
      @(negedge clk);
      guard++;
    end
    ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL pp_empty: valid %b level %0d want 0 0", evt_valid, level); end
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    wait_ts(4'd15);
    pulse[3] = 1'b1; push_exp(3);
    @(negedge clk); pulse = '0;
    wait_ts(4'd0);
    pulse[3] = 1'b1; push_exp(3);
    @(negedge clk); pulse = '0;
    @(negedge clk); @(negedge clk);
    ready = 1'b1;
    e = sb.pop_front();
    n_cmp++; if (evt_ts !== 4'd15 || e.ts !== 4'd15) begin n_bad++; $display("FAIL wrap_ts15: got %0d want 15", evt_ts); end
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (evt_ts !== 4'd0 || evt_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_ts0: got %0d valid %b want 0 valid 1", evt_ts, evt_valid); end
    @(negedge clk); ready = 1'b0;

    wait_ts(4'd3);
    pulse = 4'b1111;
    @(negedge clk);
    pulse = 4'b1000;
    @(negedge clk); pulse = '0;
    n_cmp++; if (overflow !== 1'b1 || evt_valid !== 1'b1) begin n_bad++; $display("FAIL burst_state: ovf %b valid %b want 1 1", overflow, evt_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (evt_valid !== 1'b0)      begin n_bad++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    n_cmp++; if (level !== 4'd0)          begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (overflow !== 1'b0)       begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_cmp++; if (dut.ts_ms !== 4'd0)      begin n_bad++; $display("FAIL rst_ts: got %0d want 0", dut.ts_ms); end
    n_cmp++; if (dut.pending !== 4'b0000) begin n_bad++; $display("FAIL rst_pending: got %b want 0000", dut.pending); end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    pulse[1] = 1'b1; push_exp(1);
    @(negedge clk); pulse = '0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (evt_valid !== 1'b1 || evt_key !== e.key || evt_ts !== 4'd0) begin n_bad++; $display("FAIL post_rst_evt: got %b %0d/%0d want 1 %0d/0", evt_valid, evt_key, evt_ts, e.key); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    n_cmp++; if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_pop: valid %b want 0", evt_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full_pending();
    test_ovf_clr();
    test_push_pop_full();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
